fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered fetch entries (power of two, 2..8).
REQ-002 SHALL have parameter HALT_OPCODE, default 9'h1FF, instruction encoding that stops fetch intake.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  fetch stage presents an entry.
REQ-006 SHALL have port in_pc  input  8  PC of presented entry.
REQ-007 SHALL have port in_inst  input  9  instruction word from instruction ROM.
REQ-008 SHALL have port in_ready  output  1  buffer accepts an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  oldest entry presented to decode.
REQ-010 SHALL have port out_pc  output  8  PC of oldest entry.
REQ-011 SHALL have port out_inst  output  9  instruction of oldest entry.
REQ-012 SHALL have port out_ready  input  1  decode consumes the entry this cycle.
REQ-013 SHALL have port flush  input  1  discard all entries (branch redirect).
REQ-014 SHALL have port halt_out  output  1  halt reached and buffer drained; drives the fetch stage's halt input.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (count < DEPTH) && state == FB_RUN, from registered state only (no combinational path from out_ready).
REQ-018 SHALL drive out_valid = (count != 0); out_pc/out_inst SHALL be the entry at the read pointer, held stable while out_valid && !out_ready.
REQ-019 SHALL present a pushed entry on out_* no earlier than the cycle after the push (1-cycle latency, no bypass).
REQ-020 SHALL keep count unchanged on simultaneous push and pop; increment on push only; decrement on pop only.
REQ-021 SHALL wrap read/write pointers modulo DEPTH.
REQ-022 SHALL, when full, deassert in_ready even if out_ready is high that cycle.
REQ-023 SHALL implement FSM states FB_RUN and FB_HALTED; FB_RUN -> FB_HALTED on push of in_inst == HALT_OPCODE (the halt entry itself is stored); FB_HALTED -> FB_RUN only on flush or reset.
REQ-024 SHALL assert halt_out when state == FB_HALTED and count == 0.
REQ-025 SHALL give flush priority over push and pop in the same cycle: next cycle count = 0, pointers = 0, state = FB_RUN, nothing written.
REQ-026 SHALL ignore out_ready when out_valid is low, and in_valid when in_ready is low (no state change).

Reset
REQ-027 SHALL, on reset high at a rising edge, set count = 0, pointers = 0, state = FB_RUN; hence out_valid = 0, halt_out = 0, in_ready = 1 in the following cycle.
REQ-028 SHALL give reset priority over flush, push and pop, including mid-drain and while FB_HALTED.
REQ-029 Storage contents need not be reset; out_pc/out_inst are don't-care while out_valid = 0.

Configuration
REQ-030 SHALL, with macro FETCH_BUFFER_HALT_DETECT_EN defined, implement REQ-023/REQ-024 as stated.
REQ-031 SHALL, without FETCH_BUFFER_HALT_DETECT_EN, tie halt_out to 0, remain in FB_RUN permanently, and treat HALT_OPCODE as ordinary data.

Structure
REQ-032 SHALL take PC_W = 8, INST_W = 9, default HALT_OPCODE, and typedef enum fb_state_e {FB_RUN, FB_HALTED} from shared package cpu_pkg.
REQ-033 SHALL place the entry array in one sub-module fb_storage (DEPTH x (PC_W+INST_W) registers, one write port, one asynchronous read port); pointers, count and FSM stay in fetch_buffer.

Verification
REQ-034 Reset then push pc 8'h00/inst 9'h012, out_ready = 0 -> next cycle out_valid = 1, out_pc = 8'h00, out_inst = 9'h012, count = 1.
REQ-035 Push 2 entries with out_ready = 0 -> count = 2, in_ready = 0; third in_valid ignored; pop both -> order preserved, count = 0.
REQ-036 Steady in_valid = out_ready = 1 for 10 cycles with pc 0..9 -> one entry per cycle after 1-cycle latency, pc sequence 0..9 in order, count constant at 1.
REQ-037 Push 9'h1FF at pc 8'h05 with 1 entry queued -> in_ready = 0 next cycle; halt_out = 1 only after both entries popped; macro undefined -> halt_out stays 0, in_ready stays 1.
REQ-038 Flush asserted with count = 2 concurrent with push and pop -> next cycle count = 0, out_valid = 0, in_ready = 1; flush while FB_HALTED -> halt_out = 0, FB_RUN.
REQ-039 Reset asserted while FB_HALTED with count = 1 -> next cycle count = 0, halt_out = 0, in_ready = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, default halt encoding and the
// fetch buffer state type.
package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 9;

  localparam logic [INST_W-1:0] HALT_OPCODE_DEF = 9'h1FF;

  typedef enum logic {
    FB_RUN    = 1'b0,
    FB_HALTED = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_storage.sv
// Entry array for the fetch buffer: DEPTH registers, one write port and one
// asynchronous read port. Contents are not reset.
module fb_storage #(
  parameter int DEPTH = 2,
  parameter int W     = 17,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the presented entry into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer between the fetch stage and decode: a small FIFO of
// {pc, inst} entries with flush and halt detection.
// Optional feature: define FETCH_BUFFER_HALT_DETECT_EN to stop intake after
// the halt opcode is accepted and raise halt_out once the buffer drains.
// Without it the buffer never leaves FB_RUN and halt_out is tied low.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int                DEPTH       = 2,
  parameter logic [INST_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic                       halt_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INST_W;

`ifdef FETCH_BUFFER_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  fb_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic [EW-1:0] rdata;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (count_q < CW'(DEPTH)) && (state_q == FB_RUN);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_pc    = rdata[EW-1:INST_W];
  assign out_inst  = rdata[INST_W-1:0];

  // A flush discards the cycle's push, so nothing is written then.
  fb_storage #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .we_i    (push && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_pc, in_inst}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Next-state for pointers, occupancy and halt FSM; flush overrides all.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halt_out = HALT_EN && (state_q == FB_HALTED) && (count_q == '0);

    if (flush) begin
      state_d  = FB_RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (HALT_EN && push && (in_inst == HALT_OPCODE)) begin
        state_d = FB_HALTED;
      end
    end
  end

  // State registers; reset takes priority over every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FB_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer (DEPTH = 2). Expectations follow
// FETCH_BUFFER_HALT_DETECT_EN when the halt feature is compiled in.
module tb_fetch_buffer;

`ifdef FETCH_BUFFER_HALT_DETECT_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_pc;
  logic [8:0] in_inst;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_pc;
  logic [8:0] out_inst;
  logic       out_ready;
  logic       flush;
  logic       halt_out;
  logic [1:0] count;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_buffer #(.DEPTH(2), .HALT_OPCODE(9'h1FF)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .flush     (flush),
    .halt_out  (halt_out),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_halt", 32'(halt_out), 0);

    // Single push, visible the cycle after.
    in_valid = 1'b1; in_pc = 8'h00; in_inst = 9'h012;
    chk("no_bypass", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    chk("p1_valid", 32'(out_valid), 1);
    chk("p1_pc", 32'(out_pc), 32'h00);
    chk("p1_inst", 32'(out_inst), 32'h012);
    chk("p1_count", 32'(count), 1);

    // Fill to full, third offer ignored even with out_ready high.
    in_valid = 1'b1; in_pc = 8'h01; in_inst = 9'h034;
    tick();
    chk("full_count", 32'(count), 2);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_hold_pc", 32'(out_pc), 32'h00);
    in_pc = 8'h02; in_inst = 9'h056; out_ready = 1'b1;
    chk("full_ready_low", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    chk("pop1_count", 32'(count), 1);
    chk("pop1_pc", 32'(out_pc), 32'h01);
    chk("pop1_inst", 32'(out_inst), 32'h034);
    tick();
    chk("pop2_count", 32'(count), 0);
    chk("pop2_valid", 32'(out_valid), 0);

    // Streaming: one entry per cycle, occupancy stays at 1.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc = 8'(i); in_inst = 9'(i + 9'h040);
      tick();
      chk("stream_count", 32'(count), 1);
      chk("stream_pc", 32'(out_pc), 32'(i));
      chk("stream_inst", 32'(out_inst), 32'(i + 32'h40));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 32'(count), 0);

    // Halt opcode pushed behind one queued entry.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 8'h04; in_inst = 9'h011;
    tick();
    in_pc = 8'h05; in_inst = 9'h1FF;
    tick();
    in_valid = 1'b0;
    chk("halt_count", 32'(count), 2);
    chk("halt_in_ready", 32'(in_ready), 0);
    chk("halt_early", 32'(halt_out), 0);
    out_ready = 1'b1;
    tick();
    chk("halt_pop1_count", 32'(count), 1);
    chk("halt_pop1_inst", 32'(out_inst), 32'h1FF);
    chk("halt_mid", 32'(halt_out), 0);
    chk("halt_mid_ready", 32'(in_ready), HEN ? 0 : 1);
    tick();
    out_ready = 1'b0;
    chk("halt_drained", 32'(halt_out), HEN ? 1 : 0);
    chk("halt_drained_ready", 32'(in_ready), HEN ? 0 : 1);

    // Flush while halted returns to run.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_halt", 32'(halt_out), 0);
    chk("flush_halt_ready", 32'(in_ready), 1);

    // Flush with full buffer concurrent with push and pop.
    in_valid = 1'b1; in_pc = 8'h10; in_inst = 9'h0A0;
    tick();
    in_pc = 8'h11; in_inst = 9'h0A1;
    tick();
    chk("pre_flush_count", 32'(count), 2);
    flush = 1'b1; out_ready = 1'b1; in_pc = 8'h12; in_inst = 9'h0A2;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);

    // Pointers restart at zero after flush: push and read back.
    in_valid = 1'b1; in_pc = 8'h20; in_inst = 9'h0B0;
    tick();
    in_valid = 1'b0;
    chk("post_flush_pc", 32'(out_pc), 32'h20);

    // Reset while halted with one entry still queued.
    in_valid = 1'b1; in_pc = 8'h21; in_inst = 9'h1FF;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("prerst_count", 32'(count), 1);
    chk("prerst_ready", 32'(in_ready), HEN ? 0 : 1);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    chk("rst2_count", 32'(count), 0);
    chk("rst2_halt", 32'(halt_out), 0);
    chk("rst2_in_ready", 32'(in_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
